// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Forwarding is selected at build time with PIPE_FORWARDING_EN.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  // Width of the MDU down-counter; MDU_CYCLES must fit in 1..2**CNT_W.
  localparam int CNT_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    MDU  = 1'b1
  } ctrl_state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_W  = 2'd1,
    FWD_M  = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/mdu_stall_timer.sv
// Multi-cycle MDU sequencer: holds E for MDU_CYCLES cycles per MDU op.
// mdu_start is ignored while an op is already being timed.
module mdu_stall_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic mdu_start,
  output logic mdu_stall,
  output logic mdu_busy
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ctrl_state_t         state;
  logic [CNT_W-1:0]    cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mdu_start) begin
            state <= MDU;
            cnt   <= CNT_LOAD;
          end
        end
        MDU: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // The accepting IDLE cycle counts as the first stall cycle.
  assign mdu_stall = ((state == IDLE) && mdu_start) || ((state == MDU) && (cnt != '0));
  assign mdu_busy  = (state == MDU);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage F/D/E/M/W pipeline.
// Define PIPE_FORWARDING_EN to enable operand forwarding; otherwise D stalls on RAW.
module pipe_hazard_ctrl #(
  parameter int MDU_CYCLES = 4,
  parameter int REG_W      = pipe_ctrl_pkg::REG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic             branch_d,
  input  logic             pcsrc_d,
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic [REG_W-1:0] writereg_e,
  input  logic [REG_W-1:0] writereg_m,
  input  logic [REG_W-1:0] writereg_w,
  input  logic             regwrite_e,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  input  logic             memtoreg_e,
  input  logic             memtoreg_m,
  input  logic             mdu_start_e,
  input  logic             mem_req_m,
  input  logic             mem_ready_m,
  output logic             en_f,
  output logic             en_d,
  output logic             clr_d,
  output logic             en_e,
  output logic             clr_e,
  output logic             en_m,
  output logic             clr_m,
  output logic             en_w,
  output logic             clr_w,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             fwd_a_d,
  output logic             fwd_b_d,
  output logic             mdu_busy
);

  import pipe_ctrl_pkg::*;

  // Register 0 is hardwired to zero, so it never produces a hazard or forward.
  function automatic logic reg_hit(input logic wr, input logic [REG_W-1:0] dst,
                                   input logic [REG_W-1:0] src);
    return wr && (src != '0) && (dst == src);
  endfunction

  logic     mdu_stall;
  logic     mem_stall;
  logic     lu_stall;
  logic     br_stall;
  logic     raw_stall;
  logic     d_stall;
  fwd_sel_t fwd_a_sel;
  fwd_sel_t fwd_b_sel;

  mdu_stall_timer #(
    .MDU_CYCLES(MDU_CYCLES)
  ) u_mdu_timer (
    .clk      (clk),
    .reset    (reset),
    .mdu_start(mdu_start_e),
    .mdu_stall(mdu_stall),
    .mdu_busy (mdu_busy)
  );

  assign mem_stall = mem_req_m && !mem_ready_m;

  assign lu_stall = memtoreg_e &&
                    (reg_hit(regwrite_e, writereg_e, rs_d) || reg_hit(regwrite_e, writereg_e, rt_d));

  // Branches compare in D, so any pending E result or M load must land first.
  assign br_stall = branch_d &&
                    (reg_hit(regwrite_e, writereg_e, rs_d) || reg_hit(regwrite_e, writereg_e, rt_d) ||
                     reg_hit(memtoreg_m, writereg_m, rs_d) || reg_hit(memtoreg_m, writereg_m, rt_d));

`ifdef PIPE_FORWARDING_EN

  assign raw_stall = 1'b0;

  always_comb begin
    fwd_a_sel = FWD_RF;
    if (reg_hit(regwrite_m, writereg_m, rs_e)) begin
      fwd_a_sel = FWD_M;
    end else if (reg_hit(regwrite_w, writereg_w, rs_e)) begin
      fwd_a_sel = FWD_W;
    end
  end

  always_comb begin
    fwd_b_sel = FWD_RF;
    if (reg_hit(regwrite_m, writereg_m, rt_e)) begin
      fwd_b_sel = FWD_M;
    end else if (reg_hit(regwrite_w, writereg_w, rt_e)) begin
      fwd_b_sel = FWD_W;
    end
  end

  // Only an ALU result is available in M; loads are covered by the branch stall.
  assign fwd_a_d = reg_hit(regwrite_m && !memtoreg_m, writereg_m, rs_d);
  assign fwd_b_d = reg_hit(regwrite_m && !memtoreg_m, writereg_m, rt_d);

`else

  logic unused_fwd_inputs;

  // Write-first register file covers W; anything still in E or M must drain.
  assign raw_stall = reg_hit(regwrite_e, writereg_e, rs_d) || reg_hit(regwrite_e, writereg_e, rt_d) ||
                     reg_hit(regwrite_m, writereg_m, rs_d) || reg_hit(regwrite_m, writereg_m, rt_d);

  assign fwd_a_sel = FWD_RF;
  assign fwd_b_sel = FWD_RF;
  assign fwd_a_d   = 1'b0;
  assign fwd_b_d   = 1'b0;

  assign unused_fwd_inputs = ^{rs_e, rt_e, writereg_w, regwrite_w};

`endif

  assign d_stall = lu_stall || br_stall || raw_stall;
  assign fwd_a_e = fwd_a_sel;
  assign fwd_b_e = fwd_b_sel;

  // Priority chain: each stall bubbles only the stage just below what it holds.
  always_comb begin
    en_f  = 1'b1;
    en_d  = 1'b1;
    clr_d = 1'b0;
    en_e  = 1'b1;
    clr_e = 1'b0;
    en_m  = 1'b1;
    clr_m = 1'b0;
    en_w  = 1'b1;
    clr_w = 1'b0;
    if (mem_stall) begin
      en_f  = 1'b0;
      en_d  = 1'b0;
      en_e  = 1'b0;
      en_m  = 1'b0;
      clr_w = 1'b1;
    end else if (mdu_stall) begin
      en_f  = 1'b0;
      en_d  = 1'b0;
      en_e  = 1'b0;
      clr_m = 1'b1;
    end else if (d_stall) begin
      en_f  = 1'b0;
      en_d  = 1'b0;
      clr_e = 1'b1;
    end else if (pcsrc_d) begin
      clr_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with directed vectors.
// Expected forwarding results follow PIPE_FORWARDING_EN when it is defined.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] rs_d, rt_d;
    logic       branch_d, pcsrc_d;
    logic [4:0] rs_e, rt_e, writereg_e, writereg_m, writereg_w;
    logic       regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m;
    logic       mdu_start_e, mem_req_m, mem_ready_m;
  } stim_t;

  typedef struct packed {
    logic       en_f, en_d, clr_d, en_e, clr_e, en_m, clr_m, en_w, clr_w;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       fwd_a_d, fwd_b_d, mdu_busy;
  } resp_t;

  typedef struct {
    string name;
    resp_t exp;
  } item_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
  logic       branch_d, pcsrc_d, regwrite_e, regwrite_m, regwrite_w;
  logic       memtoreg_e, memtoreg_m, mdu_start_e, mem_req_m, mem_ready_m;
  logic       en_f, en_d, clr_d, en_e, clr_e, en_m, clr_m, en_w, clr_w;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       fwd_a_d, fwd_b_d, mdu_busy;

  item_t sb[$];
  event  sample_ev;
  int    tests_run = 0;
  int    tests_failed = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_CYCLES(4), .REG_W(5)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d), .pcsrc_d(pcsrc_d),
    .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
    .mdu_start_e(mdu_start_e), .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .en_f(en_f), .en_d(en_d), .clr_d(clr_d), .en_e(en_e), .clr_e(clr_e),
    .en_m(en_m), .clr_m(clr_m), .en_w(en_w), .clr_w(clr_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
    .mdu_busy(mdu_busy)
  );

  function automatic stim_t quiet();
    stim_t s;
    s = '0;
    s.mem_ready_m = 1'b1;
    return s;
  endfunction

  function automatic stim_t load_use();
    stim_t s;
    s = quiet();
    s.writereg_e = 5'd2;
    s.regwrite_e = 1'b1;
    s.memtoreg_e = 1'b1;
    s.rs_d       = 5'd2;
    return s;
  endfunction

  function automatic resp_t nom(input logic busy);
    resp_t r;
    r = '0;
    r.en_f = 1'b1; r.en_d = 1'b1; r.en_e = 1'b1; r.en_m = 1'b1; r.en_w = 1'b1;
    r.mdu_busy = busy;
    return r;
  endfunction

  function automatic resp_t d_hold(input resp_t r);
    r.en_f = 1'b0; r.en_d = 1'b0; r.clr_e = 1'b1;
    return r;
  endfunction

  function automatic resp_t mdu_hold(input logic busy);
    resp_t r;
    r = nom(busy);
    r.en_f = 1'b0; r.en_d = 1'b0; r.en_e = 1'b0; r.clr_m = 1'b1;
    return r;
  endfunction

  function automatic resp_t mem_hold(input logic busy);
    resp_t r;
    r = nom(busy);
    r.en_f = 1'b0; r.en_d = 1'b0; r.en_e = 1'b0; r.en_m = 1'b0; r.clr_w = 1'b1;
    return r;
  endfunction

  task automatic drive(input stim_t s, input logic rst);
    reset = rst;
    rs_d = s.rs_d; rt_d = s.rt_d; branch_d = s.branch_d; pcsrc_d = s.pcsrc_d;
    rs_e = s.rs_e; rt_e = s.rt_e;
    writereg_e = s.writereg_e; writereg_m = s.writereg_m; writereg_w = s.writereg_w;
    regwrite_e = s.regwrite_e; regwrite_m = s.regwrite_m; regwrite_w = s.regwrite_w;
    memtoreg_e = s.memtoreg_e; memtoreg_m = s.memtoreg_m;
    mdu_start_e = s.mdu_start_e; mem_req_m = s.mem_req_m; mem_ready_m = s.mem_ready_m;
  endtask

  task automatic push_exp(input string name, input resp_t e);
    item_t it;
    it.name = name;
    it.exp  = e;
    sb.push_back(it);
  endtask

  // One vector per cycle: drive after the edge, sample at the falling edge.
  task automatic applyStimulus(input string name, input stim_t s, input logic rst, input resp_t e);
    @(posedge clk);
    #1;
    drive(s, rst);
    push_exp(name, e);
    @(negedge clk);
    ->sample_ev;
  endtask

  task automatic checkOutput(input item_t it);
    resp_t act;
    act = {en_f, en_d, clr_d, en_e, clr_e, en_m, clr_m, en_w, clr_w,
           fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, mdu_busy};
    tests_run++;
    if (act !== it.exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b required %b (en_f en_d clr_d en_e clr_e en_m clr_m en_w clr_w fwd_a_e fwd_b_e fwd_a_d fwd_b_d busy)",
               it.name, act, it.exp);
    end
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        it = sb.pop_front();
        checkOutput(it);
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    resp_t e;
    drive(quiet(), 1'b1);

    applyStimulus("reset_quiet", quiet(), 1'b1, nom(1'b0));
    applyStimulus("idle_nominal", quiet(), 1'b0, nom(1'b0));

    applyStimulus("load_use", load_use(), 1'b0, d_hold(nom(1'b0)));

    s = quiet(); s.regwrite_w = 1'b1; s.writereg_w = 5'd2; s.rs_e = 5'd2; s.rs_d = 5'd3;
    e = nom(1'b0); e.fwd_a_e = FWD ? 2'd1 : 2'd0;
    applyStimulus("load_use_then_fwd_w", s, 1'b0, e);

    s = quiet(); s.pcsrc_d = 1'b1;
    e = nom(1'b0); e.clr_d = 1'b1;
    applyStimulus("flush", s, 1'b0, e);

    s = load_use(); s.pcsrc_d = 1'b1;
    applyStimulus("flush_vs_load_use", s, 1'b0, d_hold(nom(1'b0)));

    s = quiet(); s.regwrite_m = 1'b1; s.writereg_m = 5'd5;
    s.regwrite_w = 1'b1; s.writereg_w = 5'd5; s.rs_e = 5'd5;
    e = nom(1'b0); e.fwd_a_e = FWD ? 2'd2 : 2'd0;
    applyStimulus("fwd_m_beats_w", s, 1'b0, e);

    s = quiet(); s.regwrite_m = 1'b1; s.regwrite_w = 1'b1; s.regwrite_e = 1'b1;
    applyStimulus("reg0_never_matches", s, 1'b0, nom(1'b0));

    s = quiet(); s.regwrite_m = 1'b1; s.writereg_m = 5'd6; s.rs_e = 5'd6;
    s.regwrite_w = 1'b1; s.writereg_w = 5'd5; s.rt_e = 5'd5;
    e = nom(1'b0); e.fwd_a_e = FWD ? 2'd2 : 2'd0; e.fwd_b_e = FWD ? 2'd1 : 2'd0;
    applyStimulus("fwd_a_m_b_w", s, 1'b0, e);

    s = quiet(); s.branch_d = 1'b1; s.regwrite_e = 1'b1; s.writereg_e = 5'd7; s.rs_d = 5'd7;
    applyStimulus("branch_vs_alu_in_e", s, 1'b0, d_hold(nom(1'b0)));

    s = quiet(); s.branch_d = 1'b1; s.regwrite_m = 1'b1; s.memtoreg_m = 1'b1;
    s.writereg_m = 5'd4; s.rt_d = 5'd4;
    applyStimulus("branch_vs_load_in_m", s, 1'b0, d_hold(nom(1'b0)));

    s = quiet(); s.branch_d = 1'b1; s.regwrite_m = 1'b1; s.writereg_m = 5'd6; s.rs_d = 5'd6;
    e = nom(1'b0); e.fwd_a_d = 1'b1;
    applyStimulus("branch_alu_in_m", s, 1'b0, FWD ? e : d_hold(nom(1'b0)));

    s = quiet(); s.regwrite_e = 1'b1; s.writereg_e = 5'd8; s.rt_d = 5'd8;
    applyStimulus("alu_raw_in_e", s, 1'b0, FWD ? nom(1'b0) : d_hold(nom(1'b0)));

    s = quiet(); s.regwrite_e = 1'b1; s.memtoreg_e = 1'b1;
    applyStimulus("load_to_reg0", s, 1'b0, nom(1'b0));

    s = quiet(); s.mem_req_m = 1'b1; s.mem_ready_m = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus("mem_wait", s, 1'b0, mem_hold(1'b0));
    s.mem_ready_m = 1'b1;
    applyStimulus("mem_ready_resume", s, 1'b0, nom(1'b0));

    s = load_use(); s.mem_req_m = 1'b1; s.mem_ready_m = 1'b0;
    applyStimulus("mem_over_load_use", s, 1'b0, mem_hold(1'b0));

    // MDU op spans 4 stall cycles; one of them overlaps a memory wait.
    s = quiet(); s.mdu_start_e = 1'b1;
    applyStimulus("mdu_c0_accept", s, 1'b0, mdu_hold(1'b0));
    s = load_use(); s.mdu_start_e = 1'b1;
    applyStimulus("mdu_c1_over_lu", s, 1'b0, mdu_hold(1'b1));
    s = quiet(); s.mdu_start_e = 1'b1; s.mem_req_m = 1'b1; s.mem_ready_m = 1'b0;
    applyStimulus("mdu_c2_mem_wins", s, 1'b0, mem_hold(1'b1));
    s = quiet(); s.mdu_start_e = 1'b1;
    applyStimulus("mdu_c3_last_stall", s, 1'b0, mdu_hold(1'b1));
    applyStimulus("mdu_c4_start_ignored", s, 1'b0, nom(1'b1));
    applyStimulus("mdu_c5_idle", quiet(), 1'b0, nom(1'b0));

    s = quiet(); s.mdu_start_e = 1'b1;
    applyStimulus("mdu_r0_accept", s, 1'b0, mdu_hold(1'b0));
    applyStimulus("mdu_r1_cnt3", s, 1'b0, mdu_hold(1'b1));
    applyStimulus("mdu_r2_cnt2", s, 1'b0, mdu_hold(1'b1));
    #2;
    drive(quiet(), 1'b1);
    push_exp("reset_mid_mdu", nom(1'b0));
    #1;
    ->sample_ev;
    applyStimulus("reset_hold", quiet(), 1'b1, nom(1'b0));
    applyStimulus("post_reset", quiet(), 1'b0, nom(1'b0));
    s = quiet(); s.mdu_start_e = 1'b1;
    applyStimulus("post_reset_mdu", s, 1'b0, mdu_hold(1'b0));

    #2;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
